// File: rtl/rd_tag_alloc_if.sv
// Destination-tag allocator bus: ID-side allocation request/grant,
// WB/EX/MEM release ports, flush, and allocator status.
interface rd_tag_alloc_if #(
   parameter int TAG_WIDTH = 3
);
   localparam int NUM_TAG = 1 << TAG_WIDTH;

   logic                 alloc_req;
   logic                 alloc_gnt;
   logic [TAG_WIDTH-1:0] alloc_tag;
   logic                 retire_en;
   logic [TAG_WIDTH-1:0] retire_tag;
   logic                 kill_ex_en;
   logic [TAG_WIDTH-1:0] kill_ex_tag;
   logic                 kill_mem_en;
   logic [TAG_WIDTH-1:0] kill_mem_tag;
   logic                 flush_all;
   logic                 tag_full;
   logic [NUM_TAG-1:0]   busy_vec;
   logic [TAG_WIDTH:0]   busy_cnt;
   logic                 tag_err;

   // Pipeline side: requests tags and reports releases.
   modport master (
      output alloc_req, retire_en, retire_tag, kill_ex_en, kill_ex_tag,
             kill_mem_en, kill_mem_tag, flush_all,
      input  alloc_gnt, alloc_tag, tag_full, busy_vec, busy_cnt, tag_err
   );

   // Allocator side.
   modport slave (
      input  alloc_req, retire_en, retire_tag, kill_ex_en, kill_ex_tag,
             kill_mem_en, kill_mem_tag, flush_all,
      output alloc_gnt, alloc_tag, tag_full, busy_vec, busy_cnt, tag_err
   );
endinterface

// File: rtl/rd_tag_alloc.sv
// Destination-tag allocator for the ID stage. Hands out unique tags
// round-robin from the registered free set, frees them on writeback or
// kill, and flags releases of tags that were not in flight.
module rd_tag_alloc #(
   parameter int TAG_WIDTH = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   rd_tag_alloc_if.slave bus
);
   localparam int NUM_TAG = 1 << TAG_WIDTH;
   localparam int CW      = TAG_WIDTH + 1;

   logic [NUM_TAG-1:0]   r_busy_vec;
   logic [CW-1:0]        r_busy_cnt;
   logic [TAG_WIDTH-1:0] r_rr_ptr;
   logic                 r_tag_err;

   logic                 w_full;
   logic                 w_gnt;
   logic [TAG_WIDTH-1:0] w_free_tag;
   logic [TAG_WIDTH-1:0] w_idx;
   logic [NUM_TAG-1:0]   w_set_mask;
   logic [NUM_TAG-1:0]   w_clr_mask;
   logic [NUM_TAG-1:0]   w_clr_eff;
   logic [CW-1:0]        w_clr_cnt;
   logic                 w_rel_err;

   // Full is purely registered so releases never reach the stall path.
   assign w_full = &r_busy_vec;
   assign w_gnt  = bus.alloc_req & ~w_full & ~bus.flush_all;

   // First free tag at or above rr_ptr with wrap; scanning downward in
   // offset lets the nearest free tag overwrite farther ones.
   always_comb begin
      w_free_tag = r_rr_ptr;
      w_idx      = r_rr_ptr;
      for (int i = NUM_TAG - 1; i >= 0; i--) begin
         w_idx = r_rr_ptr + TAG_WIDTH'(i);
         if (!r_busy_vec[w_idx]) w_free_tag = w_idx;
      end
   end

   // Grant mask; a granted tag is never busy, so it cannot collide with a clear.
   always_comb begin
      w_set_mask = '0;
      if (w_gnt) w_set_mask[w_free_tag] = 1'b1;
   end

   // Merge the three release ports; duplicates collapse in the mask.
   always_comb begin
      w_clr_mask = '0;
      w_rel_err  = 1'b0;
      if (bus.retire_en) begin
         w_clr_mask[bus.retire_tag] = 1'b1;
         if (!r_busy_vec[bus.retire_tag]) w_rel_err = 1'b1;
      end
      if (bus.kill_ex_en) begin
         w_clr_mask[bus.kill_ex_tag] = 1'b1;
         if (!r_busy_vec[bus.kill_ex_tag]) w_rel_err = 1'b1;
      end
      if (bus.kill_mem_en) begin
         w_clr_mask[bus.kill_mem_tag] = 1'b1;
         if (!r_busy_vec[bus.kill_mem_tag]) w_rel_err = 1'b1;
      end
   end

   // Only tags actually in flight reduce the count.
   always_comb begin
      w_clr_eff = w_clr_mask & r_busy_vec;
      w_clr_cnt = '0;
      for (int i = 0; i < NUM_TAG; i++) begin
         w_clr_cnt = w_clr_cnt + CW'(w_clr_eff[i]);
      end
   end

   // Tag state; flush drops everything and ignores same-cycle releases.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_busy_vec <= '0;
         r_busy_cnt <= '0;
         r_rr_ptr   <= '0;
         r_tag_err  <= 1'b0;
      end else if (bus.flush_all) begin
         r_busy_vec <= '0;
         r_busy_cnt <= '0;
      end else begin
         r_busy_vec <= (r_busy_vec & ~w_clr_eff) | w_set_mask;
         r_busy_cnt <= r_busy_cnt + CW'(w_gnt) - w_clr_cnt;
         if (w_rel_err) r_tag_err <= 1'b1;
         if (w_gnt) r_rr_ptr <= w_free_tag + TAG_WIDTH'(1);
      end
   end

   assign bus.alloc_gnt = w_gnt;
   assign bus.alloc_tag = w_free_tag;
   assign bus.tag_full  = w_full;
   assign bus.busy_vec  = r_busy_vec;
   assign bus.busy_cnt  = r_busy_cnt;
   assign bus.tag_err   = r_tag_err;
endmodule

// File: tb/tb_rd_tag_alloc.sv
// Bench for rd_tag_alloc: directed scenarios followed by random traffic,
// all checked against a set-based reference model of the tag pool.
module tb_rd_tag_alloc;
   logic clk;
   logic reset_n;
   int   n_pass;
   int   n_total;

   rd_tag_alloc_if #(.TAG_WIDTH(3)) bus ();

   rd_tag_alloc #(.TAG_WIDTH(3)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: set of in-flight tags, next-search start, error flag.
   logic [7:0] m_busy;
   int         m_rr;
   logic       m_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic drv(input logic req,
                      input logic ren, input int rtag,
                      input logic xen, input int xtag,
                      input logic men, input int mtag,
                      input logic fl);
      bus.alloc_req    = req;
      bus.retire_en    = ren;
      bus.retire_tag   = 3'(rtag);
      bus.kill_ex_en   = xen;
      bus.kill_ex_tag  = 3'(xtag);
      bus.kill_mem_en  = men;
      bus.kill_mem_tag = 3'(mtag);
      bus.flush_all    = fl;
   endtask

   task automatic idle();
      drv(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
   endtask

   // One clock cycle: check all outputs against the model mid-cycle,
   // then advance the model with what the inputs ask for.
   task automatic step();
      logic       e_full;
      logic       e_gnt;
      int         e_tag;
      logic       found;
      logic [7:0] nb;
      @(negedge clk);
      e_full = (m_busy == 8'hFF);
      e_gnt  = bus.alloc_req && !e_full && !bus.flush_all;
      e_tag  = 0;
      found  = 1'b0;
      for (int k = 0; k < 8; k++) begin
         if (!found && !m_busy[(m_rr + k) % 8]) begin
            e_tag = (m_rr + k) % 8;
            found = 1'b1;
         end
      end
      chk("alloc_gnt", 32'(bus.alloc_gnt), 32'(e_gnt));
      if (e_gnt) chk("alloc_tag", 32'(bus.alloc_tag), 32'(e_tag));
      if (bus.alloc_gnt === 1'b1) chk("granted_tag_not_busy", 32'(bus.busy_vec[bus.alloc_tag]), 32'd0);
      chk("tag_full", 32'(bus.tag_full), 32'(e_full));
      chk("busy_vec", 32'(bus.busy_vec), 32'(m_busy));
      chk("busy_cnt", 32'(bus.busy_cnt), 32'($countones(m_busy)));
      chk("tag_err", 32'(bus.tag_err), 32'(m_err));
      nb = m_busy;
      if (bus.flush_all) begin
         nb = '0;
      end else begin
         if (bus.retire_en) begin
            if (!m_busy[bus.retire_tag]) m_err = 1'b1;
            nb[bus.retire_tag] = 1'b0;
         end
         if (bus.kill_ex_en) begin
            if (!m_busy[bus.kill_ex_tag]) m_err = 1'b1;
            nb[bus.kill_ex_tag] = 1'b0;
         end
         if (bus.kill_mem_en) begin
            if (!m_busy[bus.kill_mem_tag]) m_err = 1'b1;
            nb[bus.kill_mem_tag] = 1'b0;
         end
         if (e_gnt) begin
            nb[e_tag] = 1'b1;
            m_rr = (e_tag + 1) % 8;
         end
      end
      m_busy = nb;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_busy = '0;
      m_rr   = 0;
      m_err  = 1'b0;
   endtask

   // Asynchronous reset pulse; outputs must clear before any clock edge.
   task automatic do_reset();
      idle();
      reset_n = 1'b0;
      #2;
      model_reset();
      chk("rst_busy_vec", 32'(bus.busy_vec), 32'd0);
      chk("rst_busy_cnt", 32'(bus.busy_cnt), 32'd0);
      chk("rst_tag_full", 32'(bus.tag_full), 32'd0);
      chk("rst_tag_err", 32'(bus.tag_err), 32'd0);
      chk("rst_alloc_tag", 32'(bus.alloc_tag), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   function automatic int pick_tag();
      int s;
      s = int'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) return s;
      for (int k = 0; k < 8; k++) begin
         if (m_busy[(s + k) % 8]) return (s + k) % 8;
      end
      return s;
   endfunction

   initial begin
      n_pass  = 0;
      n_total = 0;
      reset_n = 1'b1;
      idle();
      model_reset();
      #1;

      // Reset state, and grant follows request while empty.
      do_reset();
      drv(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      #1;
      chk("rst_gnt_eq_req", 32'(bus.alloc_gnt), 32'd1);
      idle();

      // Fill: tags 0..7 in order, then full.
      for (int i = 0; i < 8; i++) begin
         drv(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
         #1;
         chk("fill_tag", 32'(bus.alloc_tag), 32'(i));
         step();
      end
      chk("fill_full", 32'(bus.tag_full), 32'd1);
      chk("fill_no_gnt", 32'(bus.alloc_gnt), 32'd0);
      chk("fill_cnt", 32'(bus.busy_cnt), 32'd8);

      // Full with a same-cycle release: still no grant; next cycle tag 5.
      drv(1'b1, 1'b1, 5, 1'b0, 0, 1'b0, 0, 1'b0);
      #1;
      chk("full_rel_no_gnt", 32'(bus.alloc_gnt), 32'd0);
      step();
      drv(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      #1;
      chk("refill_gnt", 32'(bus.alloc_gnt), 32'd1);
      chk("refill_tag", 32'(bus.alloc_tag), 32'd5);
      step();
      chk("refull", 32'(bus.tag_full), 32'd1);

      // Tags 0-3 busy, rr=4; mixed releases with duplicate kill of tag 2.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drv(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
         step();
      end
      drv(1'b1, 1'b1, 1, 1'b1, 2, 1'b1, 2, 1'b0);
      #1;
      chk("mix_tag", 32'(bus.alloc_tag), 32'd4);
      step();
      chk("mix_busy", 32'(bus.busy_vec), 32'h19);
      chk("mix_cnt", 32'(bus.busy_cnt), 32'd3);
      chk("mix_err", 32'(bus.tag_err), 32'd0);

      // Only tag 7 busy with rr=7; retire 7 same cycle -> grant 0.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drv(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
         step();
      end
      drv(1'b0, 1'b1, 6, 1'b0, 0, 1'b0, 0, 1'b0);
      step();
      drv(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      step();
      drv(1'b0, 1'b1, 0, 1'b1, 1, 1'b1, 2, 1'b0);
      step();
      drv(1'b0, 1'b1, 3, 1'b1, 4, 1'b1, 5, 1'b0);
      step();
      drv(1'b0, 1'b1, 6, 1'b0, 0, 1'b0, 0, 1'b0);
      step();
      chk("wrap_pre_busy", 32'(bus.busy_vec), 32'h80);
      drv(1'b1, 1'b1, 7, 1'b0, 0, 1'b0, 0, 1'b0);
      #1;
      chk("wrap_tag", 32'(bus.alloc_tag), 32'd0);
      step();
      chk("wrap_busy", 32'(bus.busy_vec), 32'h01);
      drv(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      #1;
      chk("wrap_rr", 32'(bus.alloc_tag), 32'd1);
      step();

      // Flush with request and retire: no grant, all free, rr kept.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drv(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
         step();
      end
      drv(1'b1, 1'b1, 3, 1'b0, 0, 1'b0, 0, 1'b1);
      #1;
      chk("flush_no_gnt", 32'(bus.alloc_gnt), 32'd0);
      step();
      chk("flush_busy", 32'(bus.busy_vec), 32'd0);
      chk("flush_cnt", 32'(bus.busy_cnt), 32'd0);
      chk("flush_err", 32'(bus.tag_err), 32'd0);
      drv(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
      #1;
      chk("flush_rr_kept", 32'(bus.alloc_tag), 32'd6);
      step();

      // Release of a free tag: sticky error, cleared only by reset.
      do_reset();
      drv(1'b0, 1'b1, 6, 1'b0, 0, 1'b0, 0, 1'b0);
      step();
      chk("err_set", 32'(bus.tag_err), 32'd1);
      idle();
      for (int i = 0; i < 3; i++) step();
      chk("err_sticky", 32'(bus.tag_err), 32'd1);
      do_reset();

      // Random traffic against the model, with periodic resets.
      for (int n = 0; n < 600; n++) begin
         int rel_pct;
         if (n % 150 == 149) do_reset();
         rel_pct = ((n / 50) % 2 == 1) ? 40 : 12;
         drv($urandom_range(0, 99) < 70,
             $urandom_range(0, 99) < rel_pct, pick_tag(),
             $urandom_range(0, 99) < rel_pct / 2, pick_tag(),
             $urandom_range(0, 99) < rel_pct / 2, pick_tag(),
             $urandom_range(0, 99) < 3);
         step();
      end

      idle();
      step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/rd_tag_alloc.md
# rd_tag_alloc

Destination-tag allocator for the ID stage. It hands out unique TAG_WIDTH-bit tags to instructions that write rd, tracks which tags are in flight, and frees them on writeback or when a flush kills the owning instruction. Its grant drives the `new_tag` / `rd_wr_tag_id` path. Its `tag_full` output is ORed into `stall_D`, so decode stalls when every tag is in use.

## Interface
- TAG_WIDTH, 3, tag width; NUM_TAG = 2**TAG_WIDTH tags (0..NUM_TAG-1)
- clk  input  1  core clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- alloc_req  input  1  ID has an rd-writing instruction ready to issue (`rd_wr_en_id & ready_id & ~flush_D`)
- alloc_gnt  output  1  tag granted this cycle
- alloc_tag  output  TAG_WIDTH  granted tag, valid when alloc_gnt=1
- retire_en  input  1  WB writes the register file with a tag
- retire_tag  input  TAG_WIDTH  tag being written back
- kill_ex_en  input  1  EX-stage rd-writing instruction is flushed
- kill_ex_tag  input  TAG_WIDTH  its tag
- kill_mem_en  input  1  MEM-stage rd-writing instruction is flushed
- kill_mem_tag  input  TAG_WIDTH  its tag
- flush_all  input  1  full pipeline flush (exception/interrupt entry); frees every tag
- tag_full  output  1  no free tag; stall request to ID
- busy_vec  output  NUM_TAG  registered in-flight bitmap, bit i = tag i busy
- busy_cnt  output  TAG_WIDTH+1  number of set bits in busy_vec
- tag_err  output  1  sticky: retire/kill of a tag that was not busy

## Operation
- State: `busy_vec[NUM_TAG-1:0]`, round-robin pointer `rr_ptr[TAG_WIDTH-1:0]`, `busy_cnt`, sticky `tag_err`.
- Free set = ~busy_vec (registered value only). A tag freed in cycle N is allocatable in N+1, never in N.
- Allocation: `alloc_tag` = first free tag scanning upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NUM_TAG-1, 0, ...).
- `alloc_gnt = alloc_req & ~tag_full & ~flush_all`. Combinational, same cycle.
- On grant: busy[alloc_tag] set at the next edge; rr_ptr <= alloc_tag+1 (mod NUM_TAG).
- Release sources: retire_en, kill_ex_en, kill_mem_en, each clearing busy[tag] at the next edge. Any combination may occur in one cycle, including duplicates of the same tag.
- Release of a tag whose registered busy bit is 0 → no state change for that tag; tag_err <= 1. Only reset clears tag_err.
- Set wins over clear is impossible by construction, since a granted tag is never busy. The bench must assert alloc_tag is never busy when alloc_gnt=1.
- flush_all: busy_vec <= 0, busy_cnt <= 0, no grant that cycle. rr_ptr is unchanged. Other releases in that cycle are ignored and do not raise tag_err.
- `tag_full = &busy_vec`, from registered state only (no combinational path from releases).
- busy_cnt next = busy_cnt + grant − (number of distinct busy tags cleared). It always equals popcount(busy_vec).

## Timing
- Reset (async assert, sync-use deassert): busy_vec=0, busy_cnt=0, rr_ptr=0, tag_err=0. Outputs: tag_full=0, alloc_gnt=alloc_req, alloc_tag=0.
- Latency: request → grant 0 cycles. Grant → busy visible in busy_vec/busy_cnt/tag_full 1 cycle. Release → tag free 1 cycle.
- Full: with all NUM_TAG busy, tag_full=1 and alloc_gnt=0 regardless of same-cycle releases. A release at edge N gives tag_full=0 and a grant is possible in cycle N+1.
- Wrap-around: rr_ptr = NUM_TAG-1 with grant gives rr_ptr 0 next.
- Reset mid-operation clears all state immediately. Any tags held downstream are abandoned; the pipeline is reset with it.
- No combinational path from retire/kill inputs to any output.

## Test plan
- Reset, then alloc_req held high 8 cycles (TAG_WIDTH=3) → tags 0,1,...,7 granted in order; cycle 9: tag_full=1, alloc_gnt=0, busy_cnt=8.
- Full, then retire tag 5 at edge N → cycle N+1: tag_full=0, alloc_tag=5 (rr_ptr=0 scans to 5), alloc_gnt=1; cycle N+2 full again.
- Tags 0–3 busy, rr_ptr=4; same cycle: retire 1, kill_ex 2, kill_mem 2, alloc_req → grant tag 4; next busy_vec=8'b0001_1001, busy_cnt=3, tag_err=0.
- busy_vec=8'b1000_0000, rr_ptr=7, alloc_req, plus retire 7 in the same cycle → grant tag 0, not 7; next busy_vec=8'b0000_0001, rr_ptr=1.
- Tags 0–5 busy, flush_all with alloc_req=1 and retire 3 → alloc_gnt=0; next busy_vec=0, busy_cnt=0, tag_err=0, rr_ptr unchanged.
- retire tag 6 while busy_vec=0 → tag_err=1 next cycle and remains set; reset_n pulse low mid-cycle → all outputs return to reset values immediately.
